// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4-lite read port (AR/R) between IFU (m0) and LSU (m1), one single-beat read at a time.
// Build option ARB_RR_EN: round-robin on ties; otherwise fixed priority with m1 (LSU) over m0 (IFU).
module axi_rd_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   input  logic [ADDR_WIDTH-1:0] m0_araddr,
   output logic                  m0_rvalid,
   input  logic                  m0_rready,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic [1:0]            m0_rresp,
   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   input  logic [ADDR_WIDTH-1:0] m1_araddr,
   output logic                  m1_rvalid,
   input  logic                  m1_rready,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [1:0]            m1_rresp,
   output logic                  s_arvalid,
   input  logic                  s_arready,
   output logic [ADDR_WIDTH-1:0] s_araddr,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   input  logic [DATA_WIDTH-1:0] s_rdata,
   input  logic [1:0]            s_rresp,
   output logic [1:0]            gnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   owner_q, owner_d;
   logic   last_q, last_d;
   logic   pick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

`ifdef ARB_RR_EN
   // On a tie the master that was not served last wins; a lone requester always wins.
   always_comb begin
      if (m0_arvalid && m1_arvalid) begin
         pick = ~last_q;
      end else begin
         pick = m1_arvalid;
      end
   end
`else
   logic unused_last;

   assign pick        = m1_arvalid;
   assign unused_last = last_q;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (m0_arvalid || m1_arvalid) begin
               state_d = ST_AR;
               owner_d = pick;
            end
         end
         ST_AR: begin
            if (s_arready) begin
               state_d = ST_R;
            end
         end
         ST_R: begin
            if (s_rvalid && s_rready) begin
               state_d = ST_IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      gnt        = 2'b00;
      case (state_q)
         ST_AR: begin
            s_arvalid  = 1'b1;
            m0_arready = ~owner_q & s_arready;
            m1_arready = owner_q & s_arready;
            gnt        = owner_q ? 2'b10 : 2'b01;
         end
         ST_R: begin
            s_rready  = owner_q ? m1_rready : m0_rready;
            m0_rvalid = ~owner_q & s_rvalid;
            m1_rvalid = owner_q & s_rvalid;
            gnt       = owner_q ? 2'b10 : 2'b01;
         end
         default: ;
      endcase
   end

   // Read data and response go to both masters; only rvalid is steered by the grant.
   assign s_araddr = owner_q ? m1_araddr : m0_araddr;
   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;
   assign m0_rresp = s_rresp;
   assign m1_rresp = s_rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed reset/stall/error cases then randomized traffic.
module tb_axi_rd_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
   logic [31:0] m0_araddr, m0_rdata;
   logic [1:0]  m0_rresp;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
   logic [31:0] m1_araddr, m1_rdata;
   logic [1:0]  m1_rresp;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic [31:0] s_araddr, s_rdata;
   logic [1:0]  s_rresp;
   logic [1:0]  gnt;

   int          n_cmp = 0;
   int          n_err = 0;
   bit          slv_rand = 0;
   bit          slv_ar_block = 0;
   logic [33:0] exp_q [2][$];
   logic [31:0] req_q [2][$];
   int          served_q [$];

   axi_rd_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .gnt(gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave memory contents: a fixed function of the address.
   function automatic logic [31:0] sd(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_1234);
   endfunction

   function automatic logic [1:0] sr(input logic [31:0] a);
      return a[5:4];
   endfunction

   // Reference arbitration policy: which master wins given the requests and who was served last.
   function automatic bit pick(input bit r1, input bit r0, input bit last);
`ifdef ARB_RR_EN
      if (r1 && r0) return !last;
`endif
      return r1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit all_done();
      return req_q[0].size() == 0 && req_q[1].size() == 0 && !m0_arvalid && !m1_arvalid &&
             exp_q[0].size() == 0 && exp_q[1].size() == 0;
   endfunction

   // Slave model
   initial begin
      logic [31:0] paddr;
      bit          ar_hs, r_hs, pend;
      int          dly;
      s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
      paddr = '0; pend = 0; dly = 0;
      forever begin
         @(negedge clk);
         ar_hs = s_arvalid && s_arready;
         r_hs  = s_rvalid && s_rready;
         if (ar_hs) paddr = s_araddr;
         @(posedge clk);
         #1;
         if (rst) begin
            pend = 0; s_rvalid = 1'b0; s_arready = 1'b1;
         end else begin
            if (r_hs) s_rvalid = 1'b0;
            if (ar_hs) begin
               pend = 1;
               dly  = slv_rand ? int'($urandom_range(0, 3)) : 0;
            end
            if (pend && !s_rvalid) begin
               if (dly == 0) begin
                  s_rvalid = 1'b1; s_rdata = sd(paddr); s_rresp = sr(paddr); pend = 0;
               end else begin
                  dly--;
               end
            end
            s_arready = slv_ar_block ? 1'b0 : (slv_rand ? 1'($urandom_range(0, 1)) : 1'b1);
         end
      end
   end

   // Monitor: checks grant behaviour every cycle and pops the scoreboard on each R handshake.
   initial begin
      logic [1:0] prev_g, g, eg;
      bit         prev_rhs, win_vld, win, last_srv, own, hs;
      logic [33:0] e;
      prev_g = 0; prev_rhs = 0; win_vld = 0; win = 0; last_srv = 1;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q[0].delete(); exp_q[1].delete();
            prev_g = 0; prev_rhs = 0; win_vld = 0; last_srv = 1;
            continue;
         end
         g = gnt;
         if (win_vld) eg = win ? 2'b10 : 2'b01;
         else if (prev_g != 0 && !prev_rhs) eg = prev_g;
         else eg = 2'b00;
         chk("gnt", g, eg);
         win_vld = 0;
         if (g == 2'b00) begin
            chk("idle_quiet", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
            if (m0_arvalid || m1_arvalid) begin
               win_vld = 1;
               win     = pick(m1_arvalid, m0_arvalid, last_srv);
            end
         end else begin
            own = g[1];
            chk("non_owner_quiet", own ? {m0_arready, m0_rvalid} : {m1_arready, m1_rvalid}, 0);
            if (s_arvalid) chk("s_araddr", s_araddr, own ? m1_araddr : m0_araddr);
         end
         prev_rhs = 0;
         for (int m = 0; m < 2; m++) begin
            hs = (m == 0) ? (m0_rvalid && m0_rready) : (m1_rvalid && m1_rready);
            if (hs) begin
               chk($sformatf("m%0d_rsp_expected", m), exp_q[m].size() != 0, 1);
               if (exp_q[m].size() != 0) begin
                  e = exp_q[m].pop_front();
                  chk($sformatf("m%0d_rsp", m),
                      (m == 0) ? {m0_rresp, m0_rdata} : {m1_rresp, m1_rdata}, e);
               end
               last_srv = 1'(m);
               served_q.push_back(m);
               prev_rhs = 1;
            end
         end
         prev_g = g;
      end
   end

   // Master driver: issues queued requests, holds arvalid until accepted.
   task automatic run(input int budget, input bit rnd);
      int n;
      bit hs0, hs1;
      logic [31:0] a;
      n = 0;
      while (n < budget && !all_done()) begin
         @(negedge clk);
         hs0 = m0_arvalid && m0_arready;
         hs1 = m1_arvalid && m1_arready;
         @(posedge clk);
         #1;
         if (hs0) m0_arvalid = 1'b0;
         if (hs1) m1_arvalid = 1'b0;
         if (!m0_arvalid && req_q[0].size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
            a = req_q[0].pop_front();
            m0_araddr = a; m0_arvalid = 1'b1;
            exp_q[0].push_back({sr(a), sd(a)});
         end
         if (!m1_arvalid && req_q[1].size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
            a = req_q[1].pop_front();
            m1_araddr = a; m1_arvalid = 1'b1;
            exp_q[1].push_back({sr(a), sd(a)});
         end
         m0_rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         m1_rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         n++;
      end
      chk("run_complete", all_done(), 1);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_order [4];
      bit seen;
      rst = 1'b1;
      m0_arvalid = 0; m0_araddr = '0; m0_rready = 1;
      m1_arvalid = 0; m1_araddr = '0; m1_rready = 1;
      #22;
      chk("reset_outputs", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, gnt}, 0);
      @(posedge clk);
      #3 rst = 1'b0;

      // T1: reset asserted mid-cycle while in AR
      @(posedge clk); #1;
      m1_araddr = 32'h8000_1000; m1_arvalid = 1'b1;
      exp_q[1].push_back({sr(m1_araddr), sd(m1_araddr)});
      @(posedge clk);
      #1 chk("t1_gnt_before_rst", gnt, 2'b10);
      #2 rst = 1'b1;
      #1;
      chk("t1_async_reset", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, gnt}, 0);
      m1_arvalid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      chk("t1_after_release", {gnt, s_arvalid}, 0);

      // T2: single IFU read
      @(posedge clk); #1;
      m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
      exp_q[0].push_back({sr(m0_araddr), sd(m0_araddr)});
      @(negedge clk);
      chk("t2_idle", {gnt, s_arvalid}, 0);
      @(negedge clk);
      chk("t2_ar", {s_arvalid, gnt, m0_arready}, {1'b1, 2'b01, 1'b1});
      chk("t2_araddr", s_araddr, 32'h8000_0000);
      @(posedge clk); #1;
      m0_arvalid = 1'b0;
      @(negedge clk);
      chk("t2_r", {m0_rvalid, m1_rvalid}, 2'b10);
      chk("t2_rdata", m0_rdata, 32'h0000_0413);
      run(50, 0);

      // T5: error response forwarded
      req_q[0].push_back(32'h8000_0020);
      run(50, 0);

      // T4: AR stall with m1 owning, m0 requesting meanwhile
      @(negedge clk);
      slv_ar_block = 1;
      @(posedge clk); #1;
      m1_araddr = 32'h8000_1000; m1_arvalid = 1'b1;
      exp_q[1].push_back({sr(m1_araddr), sd(m1_araddr)});
      @(posedge clk); #1;
      m0_araddr = 32'h8000_0004; m0_arvalid = 1'b1;
      exp_q[0].push_back({sr(m0_araddr), sd(m0_araddr)});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_stall", {s_araddr, gnt, m0_arready}, {32'h8000_1000, 2'b10, 1'b0});
      end
      slv_ar_block = 0;
      served_q.delete();
      run(100, 0);
      chk("t4_order", served_q.size() == 2 && served_q[0] == 1 && served_q[1] == 0, 1);

      // T6: reset while a response is pending
      @(posedge clk); #1;
      m0_rready = 1'b0;
      m0_araddr = 32'h8000_0010; m0_arvalid = 1'b1;
      exp_q[0].push_back({sr(m0_araddr), sd(m0_araddr)});
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (m0_rvalid) seen = 1;
         else begin
            @(posedge clk); #1;
            if (m0_arvalid && dut.m0_arready === 1'b0 && gnt == 2'b01) m0_arvalid = 1'b0;
         end
      end
      chk("t6_rvalid_pending", seen, 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("t6_rvalid_dropped", {m0_rvalid, s_rready}, 0);
      m0_arvalid = 1'b0;
      m0_rready  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      served_q.delete();
      req_q[1].push_back(32'h8000_1040);
      run(50, 0);
      chk("t6_m1_served", served_q.size() == 1 && served_q[0] == 1, 1);

      // T3: back-to-back ties from a fresh reset
      pulse_reset();
      served_q.delete();
`ifdef ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{1, 1, 0, 0};
`endif
      req_q[0].push_back(32'h8000_0004); req_q[0].push_back(32'h8000_0008);
      req_q[1].push_back(32'h8000_1000); req_q[1].push_back(32'h8000_1004);
      run(100, 0);
      chk("t3_count", served_q.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < served_q.size()) chk($sformatf("t3_order%0d", i), served_q[i], exp_order[i]);

      // Randomized traffic with slave and master backpressure
      @(negedge clk);
      slv_rand = 1;
      for (int i = 0; i < 40; i++) begin
         req_q[0].push_back(32'h8000_0000 | ($urandom & 32'h0000_FFFC));
         req_q[1].push_back(32'h8001_0000 | ($urandom & 32'h0000_FFFC));
      end
      served_q.delete();
      run(20000, 1);
      chk("rand_count", served_q.size(), 80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
